// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
//   state_e   : arbiter FSM states
//   id_width  : derives the grant index width from the requester count
//   *Min/*Max : legal bounds for MAX_HOLD and TURNAROUND
package tri_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StTurn
    } state_e;

    localparam int unsigned MaxHoldMin = 1;
    localparam int unsigned MaxHoldMax = 255;
    localparam int unsigned TurnMin    = 1;
    localparam int unsigned TurnMax    = 15;

    // Counter widths sized for the largest legal MAX_HOLD / TURNAROUND.
    localparam int unsigned BeatW = 8;
    localparam int unsigned TurnW = 4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   pointer : highest-priority index (must be < NUM_REQ)
//   any_req : at least one request set
//   winner  : first set request at or after pointer, wrapping
module rr_picker #(
    parameter int unsigned NUM_REQ = 40,
    parameter int unsigned ID_W    = 6
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic               any_req,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ-1:0] rotated;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      sum;

    always_comb begin
        // Rotate so that the pointer position lands on bit 0.
        rotated = NUM_REQ'({req, req} >> pointer);
        any_req = |rotated;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = ID_W'(i);
        end
        // Un-rotate: add the pointer back, modulo NUM_REQ.
        sum = {1'b0, offset} + {1'b0, pointer};
        if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
        winner = sum[ID_W-1:0];
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-requester level requests
//   last         : final-beat marker, only the owner's bit is used
//   bus_ready    : consumer accepted the current beat
//   enable       : registered zero-or-one-hot driver enables
//   grant_valid  : an enable is high
//   grant_id     : current owner, holds the previous owner while idle
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 40,
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1,
    localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               bus_ready,
    output logic               enable [NUM_REQ],
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    if (TURNAROUND < TurnMin || TURNAROUND > TurnMax) begin : g_bad_turnaround
        $error("tri_bus_arbiter: TURNAROUND must be within 1..15");
    end
    if (MAX_HOLD < MaxHoldMin || MAX_HOLD > MaxHoldMax) begin : g_bad_max_hold
        $error("tri_bus_arbiter: MAX_HOLD must be within 1..255");
    end

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [BeatW-1:0]   beat_q;
    logic [TurnW-1:0]   turn_q;
    logic [NUM_REQ-1:0] en_q;

    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic               release_grant;
    logic [ID_W-1:0]    ptr_next;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (req),
        .pointer (ptr_q),
        .any_req (any_req),
        .winner  (winner)
    );

    always_comb begin
        // Abort on a dropped request, otherwise only an accepted beat can end the burst.
        release_grant = !req[grant_id] ||
                        (bus_ready && (last[grant_id] || beat_q == BeatW'(MAX_HOLD - 1)));
        ptr_next      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            enable[i] = en_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            beat_q      <= '0;
            turn_q      <= '0;
            en_q        <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q     <= StGrant;
                        en_q        <= NUM_REQ'(1) << winner;
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        beat_q      <= '0;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        state_q     <= StTurn;
                        en_q        <= '0;
                        grant_valid <= 1'b0;
                        ptr_q       <= ptr_next;
                        turn_q      <= TurnW'(TURNAROUND - 1);
                    end else if (bus_ready) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                StTurn: begin
                    // Requests are only looked at in the last gap cycle.
                    if (turn_q != '0) begin
                        turn_q <= turn_q - 1'b1;
                    end else if (any_req) begin
                        state_q     <= StGrant;
                        en_q        <= NUM_REQ'(1) << winner;
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        beat_q      <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: dut_a uses MAX_HOLD=8/TURNAROUND=1,
// dut_b uses MAX_HOLD=4/TURNAROUND=2. Bus invariants are checked every cycle.
module tb_tri_bus_arbiter;

    localparam int unsigned N = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [N-1:0] req_a, last_a, req_b, last_b;
    logic         ready_a, ready_b;
    logic         enable_a [N];
    logic         enable_b [N];
    logic         gv_a, gv_b;
    logic [5:0]   gid_a, gid_b;
    logic [N-1:0] en_a, en_b, prev_a, prev_b;

    int checks = 0;
    int errors = 0;

    tri_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(8), .TURNAROUND(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .last(last_a), .bus_ready(ready_a),
        .enable(enable_a), .grant_valid(gv_a), .grant_id(gid_a)
    );

    tri_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(4), .TURNAROUND(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .last(last_b), .bus_ready(ready_b),
        .enable(enable_b), .grant_valid(gv_b), .grant_id(gid_b)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            en_a[i] = enable_a[i];
            en_b[i] = enable_b[i];
        end
    end

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv(input string tag, input logic [N-1:0] en, input logic [N-1:0] prev,
                       input logic gv, input logic [5:0] gid);
        checks += 3;
        assert ($countones(en) <= 1) else begin
            errors++;
            $error("FAIL %s_onehot observed=%0h expected=zero-or-one-hot", tag, en);
        end
        assert (prev == '0 || en == '0 || en == prev) else begin
            errors++;
            $error("FAIL %s_adjacent observed=%0h expected=0 or %0h", tag, en, prev);
        end
        assert (gv === (en != '0) && (!gv || en === oh(int'(gid)))) else begin
            errors++;
            $error("FAIL %s_gid observed=gv%0b/id%0d/en%0h expected=consistent", tag, gv, gid, en);
        end
    endtask

    always @(negedge clk) begin
        inv("inv_a", en_a, prev_a, gv_a, gid_a);
        inv("inv_b", en_b, prev_b, gv_b, gid_b);
        prev_a <= en_a;
        prev_b <= en_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] seq2 [7];
    logic [6:0]   pat;

    initial begin
        req_a = '0; last_a = '0; ready_a = 1'b0;
        req_b = '0; last_b = '0; ready_b = 1'b0;
        prev_a = '0; prev_b = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        check("rst_en_a", en_a, 0);
        check("rst_gv_a", gv_a, 0);
        check("rst_gid_a", gid_a, 0);
        check("rst_en_b", en_b, 0);
        reset_n = 1'b1;

        // Single burst ended by last, then back to idle.
        req_a = oh(3); ready_a = 1'b1;
        tick();
        check("t1_grant_en", en_a, oh(3));
        check("t1_grant_id", gid_a, 3);
        check("t1_grant_gv", gv_a, 1);
        tick(); tick(); tick();
        check("t1_hold_en", en_a, oh(3));
        last_a = oh(3);
        tick();
        check("t1_rel_en", en_a, 0);
        check("t1_rel_gv", gv_a, 0);
        check("t1_rel_gid_held", gid_a, 3);
        req_a = '0; last_a = '0;
        tick();
        check("t1_turn_en", en_a, 0);
        tick();
        check("t1_idle_en", en_a, 0);

        // Pointer back to 0, then rotate through 0,5,39 with one-beat bursts.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        req_a  = oh(0) | oh(5) | oh(39);
        last_a = req_a;
        seq2[0] = oh(0);  seq2[1] = '0; seq2[2] = oh(5); seq2[3] = '0;
        seq2[4] = oh(39); seq2[5] = '0; seq2[6] = oh(0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t2_seq%0d", i), en_a, seq2[i]);
        end
        // Owner 0 drops req together with last: one release, then idle.
        req_a = '0;
        tick();
        check("t2_drop_en", en_a, 0);
        tick();
        check("t2_idle_en", en_a, 0);
        last_a = '0;

        // MAX_HOLD release, lone re-grant, then the other requester wins.
        req_a = oh(7);
        tick();
        check("t3_grant7", en_a, oh(7));
        repeat (7) tick();
        check("t3_beat8_en", en_a, oh(7));
        tick();
        check("t3_rel_en", en_a, 0);
        tick();
        check("t3_regrant7", en_a, oh(7));
        req_a = oh(7) | oh(2);
        repeat (7) tick();
        check("t3_beat8b_en", en_a, oh(7));
        tick();
        check("t3_rel2_en", en_a, 0);
        tick();
        check("t3_grant2_en", en_a, oh(2));
        check("t3_grant2_id", gid_a, 2);

        // Abort of owner 2; pointer moves to 3 so 7 beats 1.
        req_a = oh(1) | oh(7);
        tick();
        check("t5_abort_en", en_a, 0);
        check("t5_abort_gid", gid_a, 2);
        tick();
        check("t5_next_en", en_a, oh(7));

        // Reset in the middle of a grant to 12.
        req_a = '0;
        tick();
        tick();
        req_a = oh(12);
        tick();
        check("t6_grant12", en_a, oh(12));
        req_a = oh(12) | oh(1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_en", en_a, 0);
        check("t6_async_gv", gv_a, 0);
        check("t6_async_gid", gid_a, 0);
        #2 reset_n = 1'b1;
        tick();
        check("t6_restart_en", en_a, oh(1));
        check("t6_restart_id", gid_a, 1);
        req_a = '0;

        // dut_b: stalls with MAX_HOLD=4, last on the limit beat, two-cycle gap.
        pat   = 7'b1101001;
        req_b = oh(10) | oh(11);
        tick();
        for (int i = 0; i < 7; i++) begin
            ready_b = pat[i];
            if (i == 6) last_b = oh(10);
            check($sformatf("t4_hold%0d", i), en_b, oh(10));
            tick();
        end
        last_b = '0; ready_b = 1'b0;
        check("t4_gap1_en", en_b, 0);
        tick();
        check("t4_gap2_en", en_b, 0);
        tick();
        check("t4_next_en", en_b, oh(11));
        check("t4_next_id", gid_b, 11);
        req_b = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
